count_checker: RTL
==================

# count_checker

Sequence monitor for the 4-bit free-running `counter`, the consuming end of its `out` bus. It samples the counter value on qualified cycles, acquires lock onto the +1-per-sample sequence, and then flags every broken step. It also keeps saturating tallies of errors and wrap-arounds. It sits beside `counter` in benches and in integrated designs as a self-check and health monitor.

## Interface
Parameters:
- `WIDTH`, 4: width of the monitored count.
- `LOCK_COUNT`, 3: consecutive correct increments required to declare lock (1..15).
- `CNT_W`, 8: width of the error and wrap tally outputs.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low; clears all state and outputs immediately.
- `cnt_in`  in  WIDTH: count value under observation.
- `cnt_valid`  in  1: `cnt_in` is sampled only when this is high.
- `clr`  in  1: synchronous clear of state and tallies.
- `locked`  out  1: checker is tracking a correct sequence.
- `err_pulse`  out  1: one-cycle strobe per sequence break detected while locked.
- `err_count`  out  CNT_W: saturating count of errors.
- `wrap_count`  out  CNT_W: saturating count of all-ones to zero wraps seen while locked.

## Operation
- Internal state:
  - FSM with states UNSYNC, ACQUIRE and LOCKED.
  - `expected` register, WIDTH bits.
  - `match_run` counter, 4 bits.
- Arithmetic: `expected` is always `sample + 1` modulo 2^WIDTH, so 15 + 1 = 0.
- UNSYNC, on a valid sample:
  - load `expected` with sample+1.
  - clear `match_run` to 0.
  - go to ACQUIRE.
- ACQUIRE, on a valid sample:
  - Match (sample equals `expected`): `match_run` is incremented and `expected` is set to sample+1. When `match_run` reaches LOCK_COUNT, go to LOCKED and set `locked` to 1.
  - Mismatch: re-seed `expected` with sample+1, clear `match_run` to 0, and stay in ACQUIRE. No error is reported.
- LOCKED, on a valid sample:
  - Match: set `expected` to sample+1. If the sample is 0, increment `wrap_count`.
  - Mismatch: includes a stalled counter (sample equal to the previous value). The checker:
    - asserts `err_pulse` for one cycle;
    - increments `err_count`;
    - clears `locked`;
    - goes to ACQUIRE, seeded with sample+1 and `match_run` = 0.
- Cycles with `cnt_valid` = 0 change nothing: there is no timeout and idle gaps are legal.
- Tallies saturate at 2^CNT_W − 1 and never wrap.
- `clr` = 1:
  - go to UNSYNC;
  - clear `locked`, `err_pulse`, `err_count`, `wrap_count` and `match_run`;
  - any sample presented in the same cycle is discarded, because `clr` wins.
- `rst` low, including mid-operation: the same clear as `clr`, but asynchronous. The first valid sample after `rst` is released is treated as the seed.

## Timing
- All outputs are registered and are 0 while in reset.
- `locked` rises in the cycle after the edge that samples the LOCK_COUNT-th matching value. It falls in the cycle after the edge that samples a mismatch, together with `err_pulse`.
- `err_pulse` is high for exactly one cycle per error.
- `err_count` and `wrap_count` update on the same edge as the event that causes them, with one cycle of latency from the sample.
- Back-to-back valid samples give full throughput: one decision per clock.
- A mismatch on the first sample after re-entering ACQUIRE produces no `err_pulse`.

## Structure
- Package `count_check_pkg` holds:
  - the state encoding (UNSYNC = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2);
  - default parameter constants.
- Sub-module `sat_counter`:
  - parameterised width;
  - inputs: increment enable and synchronous clear;
  - resets on the same async active-low `rst`;
  - instantiated twice, once for `err_count` and once for `wrap_count`.
- The FSM, `expected` and `match_run` live in the top module.

## Test plan
All scenarios use the default parameters unless stated.
- **Lock acquisition.** Release reset, then present valid samples 5, 6, 7, 8 on consecutive cycles. Required: `locked` = 1 in the cycle after 8 is sampled; `err_count` = 0.
- **Wrap counting.** While locked, present 14, 15, 0, 1. Required: `wrap_count` goes 0→1 one cycle after 0 is sampled; no `err_pulse`; `locked` stays 1.
- **Error and relock.** While locked with `expected` = 9, present 11. Required:
  - one-cycle `err_pulse`, `err_count` = 1 and `locked` = 0, all in the next cycle;
  - then 12, 13, 14 cause `locked` to rise again;
  - `err_count` stays at 1.
- **Valid gaps and stall.** Present 3, two idle cycles, 4, 5, 6, 6.
  - The gaps are ignored and lock is reached on 6.
  - The repeated 6 produces `err_pulse` and `err_count` = 1.
- **Clear priority.** While locked with `err_count` = 2, assert `clr` with `cnt_valid` = 1 and the expected value present. Required next cycle:
  - all outputs = 0 and state UNSYNC;
  - the sample is ignored, so the next valid sample only seeds.
- **Async reset and saturation.** With `CNT_W` = 2, force 5 errors. Required: `err_count` holds at 3. Then pull `rst` low mid-cycle. Required: all outputs are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/count_check_pkg.sv
// ============================================================================
//  Module   : count_check_pkg
//  Brief    : Shared state encoding and default constants for count_checker.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_check_pkg;

    localparam int c_def_width      = 4;
    localparam int c_def_lock_count = 3;
    localparam int c_def_cnt_w      = 8;
    localparam int c_match_run_w    = 4;

    typedef enum logic [1:0] {
        ST_UNSYNC  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/count_checker_sat_counter.sv
// ============================================================================
//  Module   : sat_counter
//  Brief    : Up-counter that sticks at all-ones, with synchronous clear.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter
    import count_check_pkg::*;
#(
    parameter int W = c_def_cnt_w
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != '1)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/count_checker.sv
// ============================================================================
//  Module   : count_checker
//  Brief    : Locks onto a +1-per-sample count sequence and flags broken steps.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_checker
    import count_check_pkg::*;
#(
    parameter int WIDTH      = c_def_width,
    parameter int LOCK_COUNT = c_def_lock_count,
    parameter int CNT_W      = c_def_cnt_w
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cnt_valid,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);

    state_e                   state_q, state_d;
    logic [WIDTH-1:0]         expected_q, expected_d;
    logic [c_match_run_w-1:0] match_run_q, match_run_d;
    logic                     locked_q, locked_d;
    logic                     err_pulse_q, err_pulse_d;
    logic                     err_inc, wrap_inc;

    logic [WIDTH-1:0]         sample_inc;
    logic                     sample_hit;
    logic [c_match_run_w-1:0] run_inc;

    assign sample_inc = cnt_in + WIDTH'(1);
    assign sample_hit = (cnt_in == expected_q);
    assign run_inc    = match_run_q + c_match_run_w'(1);

    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_run_d = match_run_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;
        wrap_inc    = 1'b0;

        // clr outranks any sample presented in the same cycle
        if (clr) begin
            state_d     = ST_UNSYNC;
            match_run_d = '0;
        end else if (cnt_valid) begin
            expected_d = sample_inc;
            case (state_q)
                ST_UNSYNC: begin
                    match_run_d = '0;
                    state_d     = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (sample_hit) begin
                        match_run_d = run_inc;
                        if (run_inc == c_match_run_w'(LOCK_COUNT)) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        match_run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (sample_hit) begin
                        wrap_inc = (cnt_in == '0);
                    end else begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        match_run_d = '0;
                        state_d     = ST_ACQUIRE;
                    end
                end
                default: begin
                    match_run_d = '0;
                    state_d     = ST_UNSYNC;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_UNSYNC;
            expected_q  <= '0;
            match_run_q <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_run_q <= match_run_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .inc_i   (err_inc),
        .count_o (err_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_wrap_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (clr),
        .inc_i   (wrap_inc),
        .count_o (wrap_count)
    );

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

endmodule

`default_nettype wire
